// File: rtl/gray_ptr_conv_pipe.sv
// Gray<->binary pointer converter with input capture chain and Gray step-error monitor.
// Latency SYNC_STAGES+1 cycles; accepts a valid every cycle, no backpressure.
module gray_ptr_conv_pipe #(
  parameter int ADDRWIDTH   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ERRCNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode,
  input  logic                 din_valid,
  input  logic [ADDRWIDTH:0]   din,
  input  logic                 clr_err,
  output logic [ADDRWIDTH:0]   dout,
  output logic                 dout_valid,
  output logic                 step_err,
  output logic [ERRCNT_W-1:0]  err_cnt
);

  localparam int W = ADDRWIDTH + 1;
  localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0] s_dat;
  logic         s_vld;
  logic         s_mode;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_dat  = din;
      assign s_vld  = din_valid;
      assign s_mode = mode;
    end else begin : g_sync
      logic [W-1:0]           dat_q [SYNC_STAGES];
      logic [SYNC_STAGES-1:0] vld_q;
      logic [SYNC_STAGES-1:0] mode_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) dat_q[i] <= '0;
          vld_q  <= '0;
          mode_q <= '0;
        end else begin
          dat_q[0]  <= din;
          vld_q[0]  <= din_valid;
          mode_q[0] <= mode;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            dat_q[i]  <= dat_q[i-1];
            vld_q[i]  <= vld_q[i-1];
            mode_q[i] <= mode_q[i-1];
          end
        end
      end

      assign s_dat  = dat_q[SYNC_STAGES-1];
      assign s_vld  = vld_q[SYNC_STAGES-1];
      assign s_mode = mode_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [W-1:0] g2b;
  logic [W-1:0] b2g;
  logic [W-1:0] conv;
  logic [W-1:0] hist;
  logic [W-1:0] diff;
  logic         hist_mode;
  logic         hist_ok;
  logic         multi_bit;
  logic         chk_err;

  // Each binary bit is the parity of all Gray bits at and above it.
  always_comb begin
    g2b = '0;
    for (int i = 0; i < W; i++) g2b[i] = ^(s_dat >> i);
  end

  assign b2g       = s_dat ^ (s_dat >> 1);
  assign conv      = s_mode ? b2g : g2b;
  assign diff      = s_dat ^ hist;
  assign multi_bit = |(diff & (diff - W'(1)));
  assign chk_err   = s_vld && !s_mode && hist_ok && (hist_mode == s_mode) && multi_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      step_err   <= 1'b0;
      err_cnt    <= '0;
      hist       <= '0;
      hist_mode  <= 1'b0;
      hist_ok    <= 1'b0;
    end else begin
      dout_valid <= s_vld;
      step_err   <= chk_err;
      if (s_vld) begin
        dout      <= conv;
        hist      <= s_dat;
        hist_mode <= s_mode;
        hist_ok   <= 1'b1;
      end
      // Clear takes priority over a coincident error pulse.
      if (clr_err)
        err_cnt <= '0;
      else if (step_err && (err_cnt != CNT_MAX))
        err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_ptr_conv_pipe.sv
// Directed bench for gray_ptr_conv_pipe: default instance plus a SYNC_STAGES=0 instance.
module tb_gray_ptr_conv_pipe;

  logic       clk = 1'b0;
  logic       reset_n, mode, din_valid, clr_err;
  logic [3:0] din;
  logic [3:0] dout, dout0;
  logic       dout_valid, dout_valid0, step_err, step_err0;
  logic [7:0] err_cnt, err_cnt0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  gray_ptr_conv_pipe u_dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .din_valid(din_valid), .din(din),
    .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid), .step_err(step_err),
    .err_cnt(err_cnt)
  );

  gray_ptr_conv_pipe #(.SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .din_valid(din_valid), .din(din),
    .clr_err(clr_err), .dout(dout0), .dout_valid(dout_valid0), .step_err(step_err0),
    .err_cnt(err_cnt0)
  );

  typedef struct {
    logic       m;
    logic       v;
    logic [3:0] d;
    logic [3:0] ed;
    logic       ev;
    logic       ee;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic v, input logic [3:0] d);
    mode      = m;
    din_valid = v;
    din       = d;
  endtask

  // Streams entries back to back; entry k is visible after the third edge following its drive.
  task automatic run_tbl(input int lo, input int hi);
    int k;
    for (int j = lo; j <= hi + 2; j++) begin
      if (j <= hi) drive(tbl[j].m, tbl[j].v, tbl[j].d);
      else         drive(1'b0, 1'b0, 4'h0);
      tick();
      if (j - 2 >= lo) begin
        k = j - 2;
        chk($sformatf("tbl%0d_dout", k), dout, tbl[k].ed);
        chk($sformatf("tbl%0d_vld", k), dout_valid, tbl[k].ev);
        chk($sformatf("tbl%0d_err", k), step_err, tbl[k].ee);
      end
    end
  endtask

  initial begin
    //            m     v     din      dout     vld   err
    tbl[0]  = '{1'b1, 1'b1, 4'b0101, 4'b0111, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'b1111, 4'b1000, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'b0011, 4'b0010, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'b0010, 4'b0011, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'b1010, 4'b1100, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'b0010, 4'b0011, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'b0111, 4'b0101, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'b1111, 4'b0101, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'b1000, 4'b1111, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 4'b0011, 4'b0010, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0};

    reset_n = 1'b0;
    clr_err = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    tick();
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_valid, 0);
    chk("rst_err", step_err, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst0_vld", dout_valid0, 0);
    chk("rst0_cnt", err_cnt0, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_vld", dout_valid, 0);

    // Single Gray valid: latency 3 on default instance, 1 with no capture stages.
    drive(1'b0, 1'b1, 4'b0110);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) drive(1'b0, 1'b0, 4'h0);
      chk($sformatf("lat_vld_c%0d", k), dout_valid, (k == 3));
      chk($sformatf("lat0_vld_c%0d", k), dout_valid0, (k == 1));
      if (k == 3) chk("lat_dout", dout, 4'b0100);
      if (k == 1) chk("lat0_dout", dout0, 4'b0100);
    end

    run_tbl(0, 9);
    chk("seq_cnt", err_cnt, 1);
    run_tbl(10, 15);
    chk("seq_cnt_after_b", err_cnt, 1);

    // 299 illegal steps after the unchecked first valid in mode 0.
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, (i % 2 == 1) ? 4'b0011 : 4'b0000);
      tick();
      if (i == 100) chk("sat_step_mid", step_err, 1);
    end
    drive(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_cnt", err_cnt, 255);

    drive(1'b0, 1'b1, 4'b0000);
    tick();
    drive(1'b0, 1'b0, 4'h0);
    tick();
    tick();
    chk("clr_step", step_err, 1);
    chk("clr_cnt_before", err_cnt, 255);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_cnt", err_cnt, 0);
    tick();
    chk("clr_cnt_hold", err_cnt, 0);

    // Reset with two valids still in the capture chain.
    drive(1'b0, 1'b1, 4'b1111);
    tick();
    drive(1'b0, 1'b1, 4'b0101);
    tick();
    drive(1'b0, 1'b1, 4'b0100);
    tick();
    drive(1'b0, 1'b0, 4'h0);
    chk("pre_rst_dout", dout, 4'b1010);
    chk("pre_rst_err", step_err, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_vld", dout_valid, 0);
    chk("mid_rst_err", step_err, 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("flush_vld_c%0d", k), dout_valid, 0);
    end
    drive(1'b0, 1'b1, 4'b1010);
    tick();
    drive(1'b0, 1'b0, 4'h0);
    tick();
    chk("new_vld_early", dout_valid, 0);
    tick();
    chk("new_vld", dout_valid, 1);
    chk("new_dout", dout, 4'b1100);
    chk("new_err", step_err, 0);
    tick();
    chk("new_cnt", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_ptr_conv_pipe.md
GRAY_PTR_CONV_PIPE -- requirements
Module: gray_ptr_conv_pipe

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 3, giving a code width of ADDRWIDTH+1 bits; legal range is 1..15.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, setting the number of input capture flops; legal range is 0..3, where 0 means the input is used combinationally.
REQ-003 The block SHALL have parameter ERRCNT_W, default 8, setting the width of the error counter.
REQ-004 The block SHALL provide port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 The block SHALL provide port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL provide port mode, input, 1 bit: 0 = Gray-to-binary, 1 = binary-to-Gray.
REQ-007 The block SHALL provide port din_valid, input, 1 bit: qualifies din.
REQ-008 The block SHALL provide port din, input, ADDRWIDTH+1 bits: the code to convert.
REQ-009 The block SHALL provide port clr_err, input, 1 bit: synchronous clear of the error counter.
REQ-010 The block SHALL provide port dout, output, ADDRWIDTH+1 bits: the converted code, registered.
REQ-011 The block SHALL provide port dout_valid, output, 1 bit: qualifies dout.
REQ-012 The block SHALL provide port step_err, output, 1 bit: a one-cycle pulse flagging an illegal Gray step.
REQ-013 The block SHALL provide port err_cnt, output, ERRCNT_W bits: a saturating count of step_err pulses.

Function
REQ-014 din, din_valid and mode SHALL pass together through an SYNC_STAGES-deep register chain, giving the "synced" triple.
REQ-015 Conversion SHALL operate on the synced triple.
  - Mode 0: bin[MSB] = g[MSB]; bin[i-1] = bin[i] XOR g[i-1], for i from MSB down to 1.
  - Mode 1: g = b XOR (b >> 1).
REQ-016 dout and dout_valid SHALL be registered at the output, so total latency from din to dout is SYNC_STAGES+1 cycles.
REQ-017 dout SHALL update only on cycles where synced valid = 1.
  - dout SHALL hold its last value otherwise.
  - dout_valid SHALL equal the synced valid delayed one cycle.
REQ-018 The block SHALL keep a history register holding the last synced valid code, plus a flag hist_ok.
REQ-019 In mode 0, when synced valid = 1 and hist_ok = 1, step_err SHALL pulse high, aligned with dout_valid, if the popcount of (synced code XOR history) is greater than 1.
REQ-020 A difference of 0 bits (repeated code) SHALL be legal.
REQ-021 A wrap-around difference of 1 bit (e.g. 1000 -> 0000) SHALL be legal.
REQ-022 The history register and hist_ok SHALL update on every synced valid.
  - hist_ok SHALL be set to 1 on every synced valid.
  - The first synced valid after reset SHALL never raise step_err.
REQ-023 A change of synced mode relative to the previous synced valid SHALL clear hist_ok.
  - The first valid in the new mode SHALL NOT be checked.
REQ-024 In mode 1, step_err SHALL remain 0.
REQ-025 err_cnt SHALL increment by 1 per step_err pulse.
  - It SHALL saturate at 2^ERRCNT_W-1 and SHALL NOT wrap.
REQ-026 clr_err = 1 SHALL set err_cnt to 0 on the next edge.
  - If clr_err and step_err occur in the same cycle, the clear SHALL win.
  - The step_err pulse itself SHALL still be output.
REQ-027 Valid inputs on consecutive cycles SHALL be accepted at full throughput, with no backpressure.

Reset
REQ-028 While reset_n = 0, all flops SHALL be cleared asynchronously.
  - dout = 0, dout_valid = 0, step_err = 0, err_cnt = 0.
  - Sync chain = 0, history = 0, hist_ok = 0.
REQ-029 Reset assertion mid-stream SHALL discard all in-flight data.
  - After reset_n rises, no dout_valid SHALL appear until a new din_valid has propagated SYNC_STAGES+1 cycles.
REQ-030 Release of reset_n is assumed synchronised externally; no internal reset synchroniser SHALL be built.

Verification (ADDRWIDTH=3, SYNC_STAGES=2, ERRCNT_W=8 unless noted)
REQ-031 Mode 0, single valid din=0110 at cycle 0 -> dout=0100, dout_valid=1 at cycle 3 only.
REQ-032 Mode 1, din=0101, then 1111 on the next cycle -> dout=0111 then 1000 on consecutive cycles, step_err=0.
REQ-033 Mode 0, valid sequence 0000, 0001, 0011, 0010, 1010, 0010, 0111 -> step_err=1 only aligned with 0111.
  - Resulting err_cnt=1.
REQ-034 Mode 0, sequence 1000 -> 0000 (wrap) -> no error; then 0000 -> 0000 (repeat) -> no error.
REQ-035 300 consecutive illegal steps (alternating 0000/0011) -> err_cnt saturates at 255.
  - clr_err coincident with an error -> err_cnt=0 the next cycle.
REQ-036 reset_n pulsed low while 2 valids are in flight -> neither emerges.
  - Next valid after reset: no step_err, even if its code differs from pre-reset history in more than 1 bit.
  - Repeat REQ-031 with SYNC_STAGES=0 -> latency 1 cycle.
